// File: rtl/mx_frame_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mx_frame_buf_if : byte stream (valid/ready, last marker)           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface mx_frame_buf_if;
  logic [7:0] rdata;
  logic       rlast;
  logic       rvalid;
  logic       rready;

  modport master (output rdata, output rlast, output rvalid, input rready);
  modport slave  (input rdata, input rlast, input rvalid, output rready);
endinterface
`default_nettype wire

// File: rtl/mx_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mx_frame_buf : receive frame buffer, commits on carrier drop       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mx_frame_buf #(
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cardet,
  input  logic [7:0]                data,
  input  logic                      write,
  input  logic                      error,
  mx_frame_buf_if.master            rd,
  output logic [$clog2(DEPTH):0]    frame_cnt,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic                      frame_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, COMMIT = 2'd2, DROP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] frm_start_q, frm_start_d;
  logic [AW:0] cmt_ptr_q, cmt_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        frame_ovf_q, frame_ovf_d;

  logic [8:0]  mem [DEPTH];
  logic        mem_we;
  logic [8:0]  mem_wdata;
  logic        full;
  logic        rvalid;
  logic [8:0]  rd_word;
  logic        rd_fire;

  assign full    = ((wr_ptr_q - rd_ptr_q) == FULL_LVL);
  assign rvalid  = (rd_ptr_q != cmt_ptr_q);
  assign rd_word = rvalid ? mem[rd_ptr_q[AW-1:0]] : 9'd0;
  assign rd_fire = rvalid && rd.rready;

  assign rd.rvalid = rvalid;
  assign rd.rlast  = rd_word[8];
  assign rd.rdata  = rd_word[7:0];
  assign frame_cnt = frame_cnt_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign frame_ovf = frame_ovf_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frm_start_d = frm_start_q;
    cmt_ptr_d   = cmt_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    frame_ovf_d = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 9'd0;

    if (rd_fire) rd_ptr_d = rd_ptr_q + ONE;

    case (state_q)
      IDLE: begin
        if (cardet) begin
          state_d     = RECV;
          frm_start_d = wr_ptr_q;
          hold_v_d    = 1'b0;
        end
      end
      RECV: begin
        if (error) begin
          state_d     = DROP;
          wr_ptr_d    = frm_start_q;
          hold_v_d    = 1'b0;
          frame_err_d = 1'b1;
        end else if (write && hold_v_q && full) begin
          state_d     = DROP;
          wr_ptr_d    = frm_start_q;
          hold_v_d    = 1'b0;
          frame_ovf_d = 1'b1;
        end else begin
          // Previous byte is flushed as non-last; the newest waits in hold
          if (write) begin
            if (hold_v_q) begin
              mem_we    = 1'b1;
              mem_wdata = {1'b0, hold_q};
              wr_ptr_d  = wr_ptr_q + ONE;
            end
            hold_d   = data;
            hold_v_d = 1'b1;
          end
          if (!cardet) state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        hold_v_d = 1'b0;
        if (hold_v_q) begin
          if (!full) begin
            mem_we     = 1'b1;
            mem_wdata  = {1'b1, hold_q};
            wr_ptr_d   = wr_ptr_q + ONE;
            cmt_ptr_d  = wr_ptr_q + ONE;
            frame_ok_d = 1'b1;
          end else begin
            wr_ptr_d    = frm_start_q;
            frame_ovf_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (!cardet) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A commit and a final-byte read in one cycle cancel out
    if (frame_ok_d && !(rd_fire && rd_word[8]))      frame_cnt_d = frame_cnt_q + ONE;
    else if (!frame_ok_d && rd_fire && rd_word[8])   frame_cnt_d = frame_cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      frm_start_q <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      hold_q      <= 8'd0;
      hold_v_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      frm_start_q <= frm_start_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      frame_ovf_q <= frame_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
  end
endmodule
`default_nettype wire

// File: tb/tb_mx_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mx_frame_buf : scoreboard bench for mx_frame_buf (DEPTH = 8)    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mx_frame_buf;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cardet = 1'b0;
  logic [7:0] data = 8'd0;
  logic       write = 1'b0;
  logic       error = 1'b0;
  logic [3:0] frame_cnt;
  logic       frame_ok, frame_err, frame_ovf;

  mx_frame_buf_if rif ();

  mx_frame_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cardet    (cardet),
    .data      (data),
    .write     (write),
    .error     (error),
    .rd        (rif),
    .frame_cnt (frame_cnt),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .frame_ovf (frame_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ok_n = 0, err_n = 0, ovf_n = 0;
  logic [8:0] exp_q [$];
  logic [7:0] tx_q  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read-side scoreboard and pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (frame_ok)  ok_n++;
      if (frame_err) err_n++;
      if (frame_ovf) ovf_n++;
      if (rif.rvalid && rif.rready) begin
        if (exp_q.size() == 0) check("rd_unexpected", {23'd0, rif.rlast, rif.rdata}, 32'h1ff);
        else check("rd_byte", {23'd0, rif.rlast, rif.rdata}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit expect_commit, input bit merge_last, input bit rd_at_commit);
    int n;
    n = tx_q.size();
    cardet = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      data  = tx_q[i];
      write = 1'b1;
      if (merge_last && i == n - 1) cardet = 1'b0;
      tick();
      write = 1'b0;
      tick();
    end
    cardet = 1'b0;
    tick();
    if (rd_at_commit) rif.rready = 1'b1;
    tick();
    if (rd_at_commit) rif.rready = 1'b0;
    tick();
    if (expect_commit)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tx_q[i]});
    tx_q.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    rif.rready = 1'b1;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    tick();
    rif.rready = 1'b0;
    check("drain_left", exp_q.size(), 0);
    check("drain_rvalid", rif.rvalid, 0);
    check("drain_cnt", frame_cnt, 0);
  endtask

  initial begin
    int ok0, err0, ovf0;
    rif.rready = 1'b0;
    repeat (3) tick();
    check("rst_rvalid", rif.rvalid, 0);
    check("rst_rdata", rif.rdata, 0);
    check("rst_rlast", rif.rlast, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_pulses", {frame_ok, frame_err, frame_ovf}, 0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a frame
    cardet = 1'b1; tick();
    data = 8'hC1; write = 1'b1; tick(); write = 1'b0; tick();
    data = 8'hC2; write = 1'b1; tick(); write = 1'b0;
    rst = 1'b0; #1;
    check("midrst_outs", {rif.rvalid, rif.rlast, rif.rdata, frame_cnt, frame_ok, frame_err, frame_ovf}, 0);
    tick(); rst = 1'b1; cardet = 1'b0;
    ok0 = ok_n;
    repeat (4) tick();
    check("midrst_no_ok", ok_n - ok0, 0);
    check("midrst_rvalid", rif.rvalid, 0);

    // Good frame
    ok0 = ok_n;
    tx_q = '{8'hBB, 8'hFF, 8'h00, 8'hAA};
    send_frame(1'b1, 1'b0, 1'b0);
    check("good_ok", ok_n - ok0, 1);
    check("good_cnt", frame_cnt, 1);
    check("good_head", {rif.rvalid, rif.rlast, rif.rdata}, {2'b10, 8'hBB});
    drain();

    // Error drop, discarded byte alongside error, then a one-byte frame
    err0 = err_n; ok0 = ok_n;
    rif.rready = 1'b1;
    cardet = 1'b1; tick();
    data = 8'h11; write = 1'b1; tick(); write = 1'b0; tick();
    data = 8'h22; write = 1'b1; tick(); write = 1'b0; tick();
    data = 8'h33; write = 1'b1; error = 1'b1; tick(); write = 1'b0; error = 1'b0;
    data = 8'h44; write = 1'b1; tick(); write = 1'b0; tick();
    cardet = 1'b0; repeat (3) tick();
    check("err_pulse", err_n - err0, 1);
    check("err_no_ok", ok_n - ok0, 0);
    check("err_rvalid", rif.rvalid, 0);
    rif.rready = 1'b0;
    tx_q = '{8'h55};
    send_frame(1'b1, 1'b0, 1'b0);
    check("after_err_cnt", frame_cnt, 1);
    drain();

    // Overflow: 9 bytes fail at commit, 10 bytes fail during reception
    ovf0 = ovf_n; ok0 = ok_n;
    for (int i = 0; i < 9; i++) tx_q.push_back(8'(8'h90 + i));
    send_frame(1'b0, 1'b0, 1'b0);
    check("ovf9_pulse", ovf_n - ovf0, 1);
    check("ovf9_cnt", frame_cnt, 0);
    check("ovf9_rvalid", rif.rvalid, 0);
    ovf0 = ovf_n;
    for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'hA0 + i));
    send_frame(1'b0, 1'b0, 1'b0);
    check("ovf10_pulse", ovf_n - ovf0, 1);
    check("ovf_no_ok", ok_n - ok0, 0);
    ok0 = ok_n;
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    send_frame(1'b1, 1'b0, 1'b0);
    check("full8_ok", ok_n - ok0, 1);
    check("full8_cnt", frame_cnt, 1);
    drain();

    // Write coincident with carrier drop becomes the last byte
    tx_q = '{8'h10, 8'h7E};
    send_frame(1'b1, 1'b1, 1'b0);
    check("merge_cnt", frame_cnt, 1);
    drain();

    // Commit lands on the same edge as the previous frame's last-byte read
    tx_q = '{8'h31};
    send_frame(1'b1, 1'b0, 1'b0);
    tx_q = '{8'h41, 8'h42};
    send_frame(1'b1, 1'b0, 1'b1);
    check("coinc_cnt", frame_cnt, 1);
    check("coinc_head", {rif.rvalid, rif.rdata}, {1'b1, 8'h41});
    drain();

    // Empty carrier burst
    ok0 = ok_n; err0 = err_n; ovf0 = ovf_n;
    cardet = 1'b1; repeat (100) tick();
    cardet = 1'b0; repeat (4) tick();
    check("empty_pulses", (ok_n - ok0) + (err_n - err0) + (ovf_n - ovf0), 0);
    check("empty_cnt", frame_cnt, 0);
    check("empty_rvalid", rif.rvalid, 0);
    tx_q = '{8'h66};
    send_frame(1'b1, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
